// File: rtl/ripple_adder_sched.sv
// rtl/ripple_adder_sched.sv - two-requester scheduler sequencing OP_WIDTH-bit adds through one external 4-bit adder
// Optional signed-overflow output rsp_ovf when RIPPLE_SCHED_OVF_EN is defined.
module ripple_adder_sched #(
  parameter int OP_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_a,
  input  logic [OP_WIDTH-1:0] req0_b,
  input  logic                req0_ci,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_a,
  input  logic [OP_WIDTH-1:0] req1_b,
  input  logic                req1_ci,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [OP_WIDTH-1:0] rsp_sum,
  output logic                rsp_co,
`ifdef RIPPLE_SCHED_OVF_EN
  output logic                rsp_ovf,
`endif
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_ci,
  input  logic [3:0]          add_sum,
  input  logic                add_co
);

  localparam int NSLICE = OP_WIDTH / 4;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [OP_WIDTH-1:0] a_q;
  logic [OP_WIDTH-1:0] b_q;
  logic                ci_q;
  logic                carry_q;
  logic                rr;
  logic [KW-1:0]       k;
  logic                gnt1;

  // rr=1 gives requester 1 priority when both are valid
  assign gnt1       = req1_valid && (!req0_valid || rr);
  assign req0_ready = (state == IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state == IDLE) && gnt1;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_q[4*k +: 4];
      add_b  = b_q[4*k +: 4];
      add_ci = (k == '0) ? ci_q : carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ci_q      <= 1'b0;
      carry_q   <= 1'b0;
      rr        <= 1'b0;
      k         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
`ifdef RIPPLE_SCHED_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q     <= gnt1 ? req1_a  : req0_a;
            b_q     <= gnt1 ? req1_b  : req0_b;
            ci_q    <= gnt1 ? req1_ci : req0_ci;
            rsp_id  <= gnt1;
            rr      <= !gnt1;
            k       <= '0;
            carry_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          rsp_sum[4*k +: 4] <= add_sum;
          carry_q           <= add_co;
          k                 <= k + 1'b1;
          if (k == K_LAST) begin
            rsp_co    <= add_co;
`ifdef RIPPLE_SCHED_OVF_EN
            rsp_ovf   <= add_a[3] ^ add_b[3] ^ add_sum[3] ^ add_co;
`endif
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
